clk_div_sched: RTL and testbench
================================

Name: clk_div_sched

Overview:
- Run-time controller for the synchronous mod-N clock dividers.
- Holds the active divide ratio and generates the divided clock, plus a one-cycle tick at each divided-clock rising edge.
- Accepts new ratios through a valid/ready handshake and switches only on a period boundary, so no runt or stretched pulse is ever produced.
- Sits between the configuration register block and the divided-clock consumers.

Parameters:
- WIDTH, 8, width of the divisor and the internal period counter.
- DEFAULT_DIV, 5, divisor loaded at reset. Must be in the range 2..2^WIDTH-1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run enable; level-sensitive.
- cfg_valid  in  1  new-divisor request.
- cfg_div  in  WIDTH  requested divisor N.
- cfg_ready  out  1  controller can accept a request this cycle.
- cfg_err  out  1  one-cycle pulse: request with N<2 was rejected.
- cur_div  out  WIDTH  divisor currently in effect.
- running  out  1  high while state is RUN or PEND.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse coincident with each clk_out rising edge, registered.

Behaviour:
- Reset is synchronous and active-high on the single clock clk.
- Reset values:
  - state = IDLE, cnt = 0, cur_div = DEFAULT_DIV, pend_div = 0.
  - clk_out = 0, tick = 0, cfg_err = 0, running = 0, cfg_ready = 1.
- Period counter: cnt runs 0..cur_div-1 and wraps to 0.
- Duty cycle: clk_out = 1 when cnt < cur_div>>1, otherwise 0.
  - N=5: high 2 cycles, low 3.
  - N=4: high 2, low 2.
  - N=2: high 1, low 1.
- tick = 1 exactly in cycles where cnt == 0 and state != IDLE.
- States:
  - IDLE: cnt held at 0, outputs low.
    - en=1 → RUN.
    - The registered cnt=0 period starts next cycle: clk_out=1 and tick=1 one cycle after en is first sampled high.
  - RUN: cnt advances every cycle.
    - Accepted request (N≥2) → PEND, with pend_div = cfg_div.
    - At cnt == cur_div-1 with en=0 → IDLE.
  - PEND: cnt keeps advancing with the old cur_div.
    - At cnt == cur_div-1: cur_div <= pend_div and cnt <= 0; next state is RUN if en=1, else IDLE.
- Handshake:
  - A request is accepted when cfg_valid & cfg_ready.
  - cfg_ready = 1 in IDLE and RUN, 0 in PEND. cfg_valid must be held by the requester until accepted.
  - In IDLE, an accepted N≥2 loads cur_div directly on the next edge with no PEND.
  - If en=1 in the same cycle, the first period uses the new N.
- Rejection: an accepted request with cfg_div < 2 changes no state and pulses cfg_err for one cycle, one cycle after acceptance.
- Disable: en deasserted mid-period does not truncate the period. The output finishes the full cur_div cycles, then stays low in IDLE.
- Simultaneous en=0 and accept in RUN: the request goes to PEND and is applied at the same boundary where the block enters IDLE. cur_div reflects the new value afterwards.
- Boundary accept: an accept in RUN in the cycle where cnt == cur_div-1 is applied at the next boundary, not the current one (one full old period follows).
- Request equal to cur_div: treated like any other request, with no visible output change.
- Reset mid-operation: all state returns to reset values on the next edge. A pending divisor is discarded. clk_out goes low immediately after that edge.
- Width: cnt compares use WIDTH-bit unsigned arithmetic. Maximum N is 2^WIDTH-1, and no overflow is possible.

Test Plan:
- Reset, then en=1 with the default divisor: clk_out pattern 1,1,0,0,0 repeating (period 5), tick every 5 cycles on the clk_out rise; cur_div=5; running=1.
- In IDLE, accept cfg_div=4, then en=1: cfg_ready stays 1, cur_div=4 next cycle, clk_out 1,1,0,0 repeating.
- Running N=5, accept cfg_div=2 at cnt=1:
  - cfg_ready drops and the current 5-cycle period completes.
  - Then clk_out toggles every cycle and cur_div=2 from the boundary.
  - A second request held during PEND is not accepted until cfg_ready returns.
- Running N=6, drop en at cnt=1: clk_out stays high through cnt=2, low through cnt=5, then stays 0; running=0; tick absent afterwards.
- Request cfg_div=1, and separately cfg_div=0, in RUN: cfg_err pulses once each, cur_div unchanged, output period unaffected.
- Running N=7 with a pending divisor, assert rst for one cycle: clk_out=0, cur_div=7 (DEFAULT_DIV=7 in this run), cfg_ready=1, pending discarded, no tick until en is re-sampled.

Source files
------------

// File: rtl/clk_div_sched.sv
// -----------------------------------------------------------------------------
// clk_div_sched
// Run-time controller for a synchronous mod-N clock divider. It holds the
// divide ratio in effect, produces the divided clock and a one-cycle tick at
// every divided-clock rising edge, and takes new ratios through a valid/ready
// handshake. A new ratio only ever takes effect on a period boundary, so the
// divided clock never shows a runt or stretched pulse.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   en         run enable (level)
//   cfg_valid  new-divisor request, held by the requester until accepted
//   cfg_div    requested divisor N
//   cfg_ready  request can be accepted this cycle (low while a ratio is pending)
//   cfg_err    one-cycle pulse after a request with N < 2 was accepted and dropped
//   cur_div    divisor currently in effect
//   running    high while the divider is producing periods (RUN or PEND)
//   clk_out    divided clock, registered
//   tick       one-cycle pulse coincident with each clk_out rising edge
// -----------------------------------------------------------------------------
module clk_div_sched #(
    parameter int unsigned WIDTH       = 32'd8,
    parameter int unsigned DEFAULT_DIV = 32'd5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [WIDTH-1:0] cur_div,
    output logic             running,
    output logic             clk_out,
    output logic             tick
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO_W   = WIDTH'(2);
    localparam logic [WIDTH-1:0] ZERO_W  = WIDTH'(0);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] cur_div_r;
    logic [WIDTH-1:0] cur_div_s;
    logic [WIDTH-1:0] pend_div_r;
    logic [WIDTH-1:0] pend_div_s;
    logic             clk_out_r;
    logic             clk_out_s;
    logic             tick_r;
    logic             tick_s;
    logic             cfg_err_r;
    logic             cfg_err_s;
    logic             running_r;
    logic             running_s;
    logic             cfg_ready_r;
    logic             cfg_ready_s;

    logic             accept_s;
    logic             div_ok_s;
    logic             wrap_s;

    // Handshake and period-boundary decode shared by the next-state logic.
    // cur_div_r is never below 2, so cur_div_r - 1 cannot underflow.
    always_comb begin
        accept_s = cfg_valid & cfg_ready_r;
        div_ok_s = (cfg_div >= TWO_W);
        wrap_s   = (cnt_r == (cur_div_r - ONE_W));
    end

    // Next-state, counter, divisor and registered-output preparation.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        cur_div_s  = cur_div_r;
        pend_div_s = pend_div_r;
        cfg_err_s  = accept_s & ~div_ok_s;

        case (state_r)
            ST_IDLE: begin
                cnt_s = ZERO_W;
                // In IDLE a valid ratio is installed directly: there is no
                // period in flight that it could cut short.
                if (accept_s && div_ok_s) begin
                    cur_div_s = cfg_div;
                end else begin
                    cur_div_s = cur_div_r;
                end
                if (en) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (wrap_s) begin
                    cnt_s = ZERO_W;
                end else begin
                    cnt_s = cnt_r + ONE_W;
                end
                // An accepted ratio always parks in PEND, even on the last
                // count of a period, so a full old period always follows.
                if (accept_s && div_ok_s) begin
                    state_s    = ST_PEND;
                    pend_div_s = cfg_div;
                end else if (wrap_s && !en) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PEND: begin
                if (wrap_s) begin
                    cnt_s     = ZERO_W;
                    cur_div_s = pend_div_r;
                    if (en) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s   = cnt_r + ONE_W;
                    state_s = ST_PEND;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = ZERO_W;
            end
        endcase

        // Outputs are computed from the next state so that the registered
        // copies line up with the registered counter.
        running_s   = (state_s != ST_IDLE);
        cfg_ready_s = (state_s != ST_PEND);
        clk_out_s   = running_s && (cnt_s < (cur_div_s >> 1));
        tick_s      = running_s && (cnt_s == ZERO_W);
    end

    // State, counter, divisor and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= ZERO_W;
            cur_div_r   <= DIV_RST;
            pend_div_r  <= ZERO_W;
            clk_out_r   <= 1'b0;
            tick_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
            running_r   <= 1'b0;
            cfg_ready_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            cur_div_r   <= cur_div_s;
            pend_div_r  <= pend_div_s;
            clk_out_r   <= clk_out_s;
            tick_r      <= tick_s;
            cfg_err_r   <= cfg_err_s;
            running_r   <= running_s;
            cfg_ready_r <= cfg_ready_s;
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign cfg_err   = cfg_err_r;
    assign cur_div   = cur_div_r;
    assign running   = running_r;
    assign clk_out   = clk_out_r;
    assign tick      = tick_r;

endmodule

// File: tb/tb_clk_div_sched.sv
// -----------------------------------------------------------------------------
// Self-checking bench for clk_div_sched. Two instances (default divisor 5 and
// 7) share all inputs. A behavioural model tracks, per instance, whether the
// divider is active, the position inside the current period, the divisor and
// an optional pending divisor; every cycle both instances are compared with it.
// Directed sequences add literal expectations, then randomized traffic runs.
// -----------------------------------------------------------------------------
module tb_clk_div_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;

    logic         cfg_ready0, cfg_err0, running0, clk_out0, tick0;
    logic [W-1:0] cur_div0;
    logic         cfg_ready1, cfg_err1, running1, clk_out1, tick1;
    logic [W-1:0] cur_div1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    clk_div_sched #(.WIDTH(W), .DEFAULT_DIV(5)) u_dut5 (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready0), .cfg_err(cfg_err0), .cur_div(cur_div0),
        .running(running0), .clk_out(clk_out0), .tick(tick0)
    );

    clk_div_sched #(.WIDTH(W), .DEFAULT_DIV(7)) u_dut7 (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready1), .cfg_err(cfg_err1), .cur_div(cur_div1),
        .running(running1), .clk_out(clk_out1), .tick(tick1)
    );

    // ---------------- behavioural model ----------------
    bit m_act  [2];
    int m_pos  [2];
    int m_div  [2];
    bit m_pv   [2];
    int m_pend [2];
    bit m_err  [2];
    int m_def  [2] = '{5, 7};
    bit m_acc0;

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit acc;
            bit ok;
            bit last;
            if (rst) begin
                m_act[i] = 1'b0; m_pos[i] = 0; m_div[i] = m_def[i];
                m_pv[i] = 1'b0; m_pend[i] = 0; m_err[i] = 1'b0;
                acc = 1'b0;
            end else begin
                acc = cfg_valid && !m_pv[i];
                ok  = (int'(cfg_div) >= 2);
                m_err[i] = acc && !ok;
                if (!m_act[i]) begin
                    if (acc && ok) m_div[i] = int'(cfg_div);
                    if (en) begin
                        m_act[i] = 1'b1;
                        m_pos[i] = 0;
                    end
                end else begin
                    last = (m_pos[i] == m_div[i] - 1);
                    m_pos[i] = last ? 0 : m_pos[i] + 1;
                    if (m_pv[i]) begin
                        if (last) begin
                            m_div[i] = m_pend[i];
                            m_pv[i]  = 1'b0;
                            m_act[i] = en;
                        end
                    end else if (acc && ok) begin
                        m_pv[i]   = 1'b1;
                        m_pend[i] = int'(cfg_div);
                    end else if (last && !en) begin
                        m_act[i] = 1'b0;
                    end
                end
            end
            if (i == 0) m_acc0 = acc;
        end
    endtask

    function automatic logic [12:0] exp_vec(int i);
        logic co, tk;
        co = m_act[i] && (m_pos[i] < m_div[i] / 2);
        tk = m_act[i] && (m_pos[i] == 0);
        return {co, tk, m_act[i], !m_pv[i], m_err[i], W'(m_div[i])};
    endfunction

    // One clock: update model, let the DUT take the edge, compare at negedge.
    task automatic cycle();
        logic [12:0] got0, got1, e0, e1;
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        got0 = {clk_out0, tick0, running0, cfg_ready0, cfg_err0, cur_div0};
        got1 = {clk_out1, tick1, running1, cfg_ready1, cfg_err1, cur_div1};
        e0 = exp_vec(0);
        e1 = exp_vec(1);
        checks++;
        if (got0 !== e0) begin
            failures++;
            $display("FAIL model_cmp inst=div5 cyc=%0d got={co,tk,run,rdy,err,div}=%b required=%b", cyc, got0, e0);
        end
        checks++;
        if (got1 !== e1) begin
            failures++;
            $display("FAIL model_cmp inst=div7 cyc=%0d got={co,tk,run,rdy,err,div}=%b required=%b", cyc, got1, e1);
        end
    endtask

    task automatic lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    initial begin
        int pat5 [5] = '{1, 1, 0, 0, 0};
        int pat4 [4] = '{1, 1, 0, 0};
        int dis_co  [6] = '{1, 0, 0, 0, 0, 0};
        int dis_run [6] = '{1, 1, 1, 1, 0, 0};
        int n;
        logic [12:0] ev;

        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        @(negedge clk);

        // Reset state.
        cycle();
        lit("rst_clk_out", clk_out0, 0);
        lit("rst_cur_div", cur_div0, 5);
        lit("rst_cfg_ready", cfg_ready0, 1);
        lit("rst_running", running0, 0);

        // Default divisor 5: pattern 1,1,0,0,0, tick on each rise.
        rst = 1'b0; en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            ev = exp_vec(0);
            lit("n5_clk_out", clk_out0, pat5[k % 5]);
            lit("n5_model_clk_out", ev[12], pat5[k % 5]);
            lit("n5_tick", tick0, (k % 5 == 0) ? 1 : 0);
            lit("n5_running", running0, 1);
        end

        // Stop, then load 4 in IDLE and restart.
        en = 1'b0;
        n = 0;
        while (m_act[0] && n < 20) begin cycle(); n++; end
        lit("idle_reached", m_act[0] ? 1 : 0, 0);
        cfg_valid = 1'b1; cfg_div = 8'd4;
        cycle();
        lit("idle_load_cur_div", cur_div0, 4);
        lit("idle_load_ready", cfg_ready0, 1);
        cfg_valid = 1'b0; en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            lit("n4_clk_out", clk_out0, pat4[k % 4]);
        end

        // Running 5, request 2 at cnt=1; second request held across PEND.
        rst = 1'b1; en = 1'b0;
        cycle();
        rst = 1'b0; en = 1'b1;
        cycle(); cycle();
        cfg_valid = 1'b1; cfg_div = 8'd2;
        cycle();
        lit("pend_ready_low", cfg_ready0, 0);
        lit("pend_old_div", cur_div0, 5);
        cfg_div = 8'd3;
        cycle();
        lit("pend_hold_ready", cfg_ready0, 0);
        cycle();
        cycle();
        lit("sw2_cur_div", cur_div0, 2);
        lit("sw2_clk_out", clk_out0, 1);
        lit("sw2_tick", tick0, 1);
        lit("sw2_ready", cfg_ready0, 1);
        cycle();
        lit("sw2_clk_low", clk_out0, 0);
        lit("second_req_ready", cfg_ready0, 0);
        cfg_valid = 1'b0;
        cycle();
        lit("sw3_cur_div", cur_div0, 3);
        lit("sw3_clk_out", clk_out0, 1);

        // Rejected divisors 1 and 0 while running at 3.
        for (int k = 0; k < 2; k++) begin
            cfg_valid = 1'b1; cfg_div = W'(1 - k);
            cycle();
            cfg_valid = 1'b0;
            lit("rej_err_pulse", cfg_err0, 1);
            lit("rej_cur_div", cur_div0, 3);
            cycle();
            lit("rej_err_clear", cfg_err0, 0);
        end

        // Switch to 6, drop en at cnt=1: period completes, then stays low.
        cfg_valid = 1'b1; cfg_div = 8'd6;
        n = 0;
        while (n < 30 && !(m_act[0] && !m_pv[0] && m_div[0] == 6 && m_pos[0] == 1)) begin
            cycle();
            if (m_acc0) cfg_valid = 1'b0;
            n++;
        end
        lit("n6_reached", n < 30 ? 1 : 0, 1);
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            lit("dis_clk_out", clk_out0, dis_co[k]);
            lit("dis_running", running0, dis_run[k]);
            lit("dis_tick", tick0, 0);
        end

        // Default-7 instance: reset while a divisor is pending.
        rst = 1'b1;
        cycle();
        rst = 1'b0; en = 1'b1;
        cycle(); cycle(); cycle();
        cfg_valid = 1'b1; cfg_div = 8'd4;
        cycle();
        cfg_valid = 1'b0;
        lit("d7_pend_ready", cfg_ready1, 0);
        rst = 1'b1; en = 1'b0;
        cycle();
        lit("d7_rst_clk_out", clk_out1, 0);
        lit("d7_rst_cur_div", cur_div1, 7);
        lit("d7_rst_ready", cfg_ready1, 1);
        rst = 1'b0;
        cycle();
        lit("d7_no_tick", tick1, 0);
        lit("d7_pend_dropped", cur_div1, 7);
        en = 1'b1;
        cycle();
        lit("d7_restart_tick", tick1, 1);
        lit("d7_restart_div", cur_div1, 7);

        // Randomized traffic; requester holds valid until instance 0 accepts.
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            if (!cfg_valid && $urandom_range(0, 5) == 0) begin
                int r;
                cfg_valid = 1'b1;
                r = $urandom_range(0, 9);
                if (r == 0)      cfg_div = 8'd0;
                else if (r == 1) cfg_div = 8'd1;
                else if (r == 2) cfg_div = W'($urandom_range(200, 255));
                else             cfg_div = W'($urandom_range(2, 9));
            end
            cycle();
            if (m_acc0) cfg_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
